wishbone_mailbox_responder: RTL and testbench

Wishbone classic responder (slave) that terminates bus cycles issued by wishbone_manager through the arbitrator/decoder, i.e. the peripheral end of the bus. It exposes control/status/scratch registers and two word FIFOs. The TX FIFO is filled by bus writes and drained by a user design over valid/ready. The RX FIFO is filled by the design and drained by bus reads. Wait-state insertion is configurable so manager BUSY/ACK timing can be exercised.

---
 rtl/wishbone_mailbox_pkg.sv | 17 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/wishbone_mailbox_responder.sv | 132 +++++++++++++
 tb/tb_wishbone_mailbox_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/wishbone_mailbox_pkg.sv
// wishbone_mailbox_pkg: register offsets, CTRL/STATUS bit indices, FSM state type and byte-mask helper
package wishbone_mailbox_pkg;
    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_STATUS  = 8'h04;
    localparam logic [7:0] OFF_TXDATA  = 8'h08;
    localparam logic [7:0] OFF_RXDATA  = 8'h0C;
    localparam logic [7:0] OFF_SCRATCH = 8'h10;
    localparam int CTRL_TX_CLR = 0;
    localparam int CTRL_RX_CLR = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_UNF   = 5;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock word FIFO with push/pop/clear and occupancy count
// Ports: clk_i, rst_ni (async active-low), clear_i (empties FIFO, wins over push/pop),
//        push_i/data_i (accepted when not full or popping), pop_i (ignored when empty),
//        data_o (head), full_o, empty_o, count_o (0..DEPTH)
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;
    assign empty_o = cnt_q == '0;
    // DEPTH is a power of two, so the count MSB alone marks full
    assign full_o  = cnt_q[AW];
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/wishbone_mailbox_responder.sv
// wishbone_mailbox_responder: Wishbone classic slave with CTRL/STATUS/SCRATCH registers and TX/RX mailbox FIFOs
// Ports: CLK, nRST (async active-low); bus CYC_I/STB_I/WE_I/ADR_I/DAT_I/SEL_I -> ACK_O/DAT_O;
//        TX stream TX_DATA_O/TX_VALID_O/TX_READY_I; RX stream RX_DATA_I/RX_VALID_I/RX_READY_O; IRQ_O
module wishbone_mailbox_responder
    import wishbone_mailbox_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    input  logic [3:0]  SEL_I,
    output logic        ACK_O,
    output logic [31:0] DAT_O,
    output logic [31:0] TX_DATA_O,
    output logic        TX_VALID_O,
    input  logic        TX_READY_I,
    input  logic [31:0] RX_DATA_I,
    input  logic        RX_VALID_I,
    output logic        RX_READY_O,
    output logic        IRQ_O
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          we_q, ack_q, irq_q, irq_en_q, tx_ovf_q, rx_unf_q;
    logic          irq_en_d, tx_ovf_d, rx_unf_d;
    logic [7:0]    adr_q;
    logic [31:0]   dat_q, scratch_q, scratch_d, rdata, status, rx_head;
    logic [3:0]    sel_q;
    logic          wr, rd, is_ctrl, is_status, is_txd, is_rxd, is_scr;
    logic          ctrl_wr, w1c, tx_push, tx_pop, rx_pop, rx_push;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          unused_adr;
    assign unused_adr = ^ADR_I[31:8];
    // Side effects only happen in the single ACK cycle, using the captured request
    assign wr        = ack_q & we_q;
    assign rd        = ack_q & ~we_q;
    assign is_ctrl   = adr_q == OFF_CTRL;
    assign is_status = adr_q == OFF_STATUS;
    assign is_txd    = adr_q == OFF_TXDATA;
    assign is_rxd    = adr_q == OFF_RXDATA;
    assign is_scr    = adr_q == OFF_SCRATCH;
    assign ctrl_wr   = wr & is_ctrl & sel_q[0];
    assign w1c       = wr & is_status & sel_q[0];
    assign tx_push   = wr & is_txd;
    assign tx_pop    = TX_VALID_O & TX_READY_I;
    assign rx_pop    = rd & is_rxd & ~rx_empty;
    assign rx_push   = RX_VALID_I & RX_READY_O;
    assign TX_VALID_O = ~tx_empty;
    assign RX_READY_O = ~rx_full;
    assign ACK_O      = ack_q;
    assign IRQ_O      = irq_q;
    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tx (
        .clk_i(CLK), .rst_ni(nRST), .clear_i(ctrl_wr & dat_q[CTRL_TX_CLR]),
        .push_i(tx_push), .pop_i(tx_pop), .data_i(dat_q & byte_mask(sel_q)),
        .data_o(TX_DATA_O), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
    );
    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_rx (
        .clk_i(CLK), .rst_ni(nRST), .clear_i(ctrl_wr & dat_q[CTRL_RX_CLR]),
        .push_i(rx_push), .pop_i(rx_pop), .data_i(RX_DATA_I),
        .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
    );
    assign status = {8'h00, 8'(rx_cnt), 8'(tx_cnt), 2'b00, rx_unf_q, tx_ovf_q,
                     rx_empty, rx_full, tx_empty, tx_full};
    assign rdata = is_ctrl   ? {29'b0, irq_en_q, 2'b00} :
                   is_status ? status :
                   is_rxd    ? (rx_empty ? 32'h0 : rx_head) :
                   is_scr    ? scratch_q : 32'h0;
    assign DAT_O = rd ? rdata : 32'h0;
    // Sticky set takes priority over a same-cycle write-1-to-clear
    assign tx_ovf_d  = (tx_push & tx_full & ~tx_pop) | (tx_ovf_q & ~(w1c & dat_q[ST_TX_OVF]));
    assign rx_unf_d  = (rd & is_rxd & rx_empty) | (rx_unf_q & ~(w1c & dat_q[ST_RX_UNF]));
    assign irq_en_d  = ctrl_wr ? dat_q[CTRL_IRQ_EN] : irq_en_q;
    assign scratch_d = (wr & is_scr) ? (scratch_q & ~byte_mask(sel_q)) | (dat_q & byte_mask(sel_q)) : scratch_q;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (CYC_I & STB_I) begin
                    we_q  <= WE_I;
                    adr_q <= ADR_I[7:0];
                    dat_q <= DAT_I;
                    sel_q <= SEL_I;
                    cnt_q <= 4'(WAIT_STATES);
                    state_q <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                    ack_q   <= WAIT_STATES == 0;
                end
                S_WAIT: if (!(CYC_I & STB_I)) begin
                    state_q <= S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_q <= S_ACK;
                    ack_q   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            irq_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
            rx_unf_q  <= 1'b0;
            scratch_q <= '0;
        end else begin
            irq_q     <= irq_en_q & (~rx_empty | tx_ovf_q | rx_unf_q);
            irq_en_q  <= irq_en_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_unf_q  <= rx_unf_d;
            scratch_q <= scratch_d;
        end
    end
endmodule

// File: tb/tb_wishbone_mailbox_responder.sv
// tb_wishbone_mailbox_responder: scoreboard bench for the mailbox responder (WAIT_STATES=1 and 3 instances)
module tb_wishbone_mailbox_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc_a, stb_a, cyc_b, stb_b, we, tx_ready, rx_valid;
    logic [31:0] adr, dat, rx_data;
    logic [3:0]  sel;
    logic        ack_a, ack_b, txv_a, txv_b, rxr_a, rxr_b, irq_a, irq_b;
    logic [31:0] dato_a, dato_b, txd_a, txd_b;
    int          n_cmp = 0, n_err = 0, lat;
    logic [31:0] rd_exp[$], tx_exp[$];
    always #5 clk = ~clk;
    wishbone_mailbox_responder #(.FIFO_DEPTH(8), .WAIT_STATES(1)) dut_a (
        .CLK(clk), .nRST(rst_n), .CYC_I(cyc_a), .STB_I(stb_a), .WE_I(we), .ADR_I(adr),
        .DAT_I(dat), .SEL_I(sel), .ACK_O(ack_a), .DAT_O(dato_a), .TX_DATA_O(txd_a),
        .TX_VALID_O(txv_a), .TX_READY_I(tx_ready), .RX_DATA_I(rx_data), .RX_VALID_I(rx_valid),
        .RX_READY_O(rxr_a), .IRQ_O(irq_a)
    );
    wishbone_mailbox_responder #(.FIFO_DEPTH(8), .WAIT_STATES(3)) dut_b (
        .CLK(clk), .nRST(rst_n), .CYC_I(cyc_b), .STB_I(stb_b), .WE_I(we), .ADR_I(adr),
        .DAT_I(dat), .SEL_I(sel), .ACK_O(ack_b), .DAT_O(dato_b), .TX_DATA_O(txd_b),
        .TX_VALID_O(txv_b), .TX_READY_I(1'b0), .RX_DATA_I(rx_data), .RX_VALID_I(1'b0),
        .RX_READY_O(rxr_b), .IRQ_O(irq_b)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    task automatic bus(input string tag, input bit b, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        bit          got_ack = 1'b0;
        logic [31:0] exp = 32'h0;
        if (!w) exp = rd_exp.pop_front();
        we = w; adr = a; dat = d; sel = s;
        if (b) {cyc_b, stb_b} = 2'b11;
        else {cyc_a, stb_a} = 2'b11;
        lat = 0;
        while (!got_ack && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            got_ack = b ? ack_b : ack_a;
        end
        if (!got_ack) check({tag, "_ack"}, 32'(got_ack), 32'd1);
        else if (!w) check(tag, b ? dato_b : dato_a, exp);
        {cyc_a, stb_a, cyc_b, stb_b} = 4'b0;
        we = 1'b0;
        @(posedge clk); #1;
    endtask
    task automatic rd(input string tag, input bit b, input logic [31:0] a, input logic [31:0] exp);
        rd_exp.push_back(exp);
        bus(tag, b, 1'b0, a, 32'h0, 4'hF);
    endtask
    task automatic wr(input string tag, input bit b, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        bus(tag, b, 1'b1, a, d, s);
    endtask
    task automatic tx_drain(input string tag);
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (txv_a) begin
                if (tx_exp.size() != 0) check(tag, txd_a, tx_exp.pop_front());
                else check({tag, "_extra"}, 32'(txv_a), 32'd0);
            end
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        check({tag, "_left"}, 32'(tx_exp.size()), 32'd0);
        check({tag, "_valid"}, 32'(txv_a), 32'd0);
    endtask
    task automatic rx_push(input logic [31:0] d);
        rx_data = d; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bit seen;
        rst_n = 1'b0;
        {cyc_a, stb_a, cyc_b, stb_b, we, tx_ready, rx_valid} = '0;
        adr = '0; dat = '0; sel = '0; rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_dat", dato_a, 32'h0);
        check("rst_txv", 32'(txv_a), 32'd0);
        check("rst_irq", 32'(irq_a), 32'd0);
        rd("rst_status", 0, 32'h04, 32'h0000_000A);
        wr("scr_sel5", 0, 32'h10, 32'h1122_3344, 4'h5);
        rd("scr_sel5_rd", 0, 32'h10, 32'h0022_0044);
        wr("scr_full", 0, 32'h3100_0010, 32'hDEAD_BEEF, 4'hF);
        check("lat_w", 32'(lat), 32'd2);
        rd("scr_full_rd", 0, 32'h3100_0010, 32'hDEAD_BEEF);
        check("lat_r", 32'(lat), 32'd2);
        for (int i = 1; i <= 8; i++) begin
            wr("tx_fill", 0, 32'h08, 32'(i), 4'hF);
            tx_exp.push_back(32'(i));
        end
        rd("tx_full_status", 0, 32'h04, 32'h0000_0809);
        wr("tx_ovf_wr", 0, 32'h08, 32'd9, 4'hF);
        rd("tx_ovf_status", 0, 32'h04, 32'h0000_0819);
        tx_drain("tx_seq");
        wr("ovf_w1c", 0, 32'h04, 32'h10, 4'h1);
        wr("tx_mask", 0, 32'h08, 32'hAABB_CCDD, 4'h3);
        tx_exp.push_back(32'h0000_CCDD);
        tx_drain("tx_mask");
        rd("idle_status", 0, 32'h04, 32'h0000_000A);
        rd("txdata_rd", 0, 32'h08, 32'h0);
        wr("irq_en", 0, 32'h00, 32'h4, 4'h1);
        rd("ctrl_rd", 0, 32'h00, 32'h4);
        rd("rx_unf_dat", 0, 32'h0C, 32'h0);
        rd("rx_unf_status", 0, 32'h04, 32'h0000_002A);
        check("irq_unf", 32'(irq_a), 32'd1);
        wr("unf_w1c", 0, 32'h04, 32'h20, 4'h1);
        @(posedge clk); #1;
        check("irq_unf_clr", 32'(irq_a), 32'd0);
        rd("unf_clr_status", 0, 32'h04, 32'h0000_000A);
        check("rx_ready", 32'(rxr_a), 32'd1);
        rx_push(32'hA5);
        @(posedge clk); #1;
        check("irq_rx", 32'(irq_a), 32'd1);
        rd("rx_status", 0, 32'h04, 32'h0001_0002);
        rd("rx_pop", 0, 32'h0C, 32'hA5);
        rd("rx_pop_status", 0, 32'h04, 32'h0000_000A);
        check("irq_rx_clr", 32'(irq_a), 32'd0);
        wr("clr_tx", 0, 32'h08, 32'h77, 4'hF);
        rx_push(32'h11);
        rx_push(32'h22);
        rd("pre_clr_status", 0, 32'h04, 32'h0002_0100);
        wr("ctrl_clr", 0, 32'h00, 32'h3, 4'h1);
        rd("post_clr_status", 0, 32'h04, 32'h0000_000A);
        rd("post_clr_ctrl", 0, 32'h00, 32'h0);
        check("post_clr_txv", 32'(txv_a), 32'd0);
        wr("unmapped_w", 0, 32'h40, 32'h1234_5678, 4'hF);
        rd("unmapped_r", 0, 32'h40, 32'h0);
        rd("unmapped_scr", 0, 32'h10, 32'hDEAD_BEEF);
        wr("b_tx", 1, 32'h08, 32'h55, 4'hF);
        check("b_lat", 32'(lat), 32'd4);
        we = 1'b1; adr = 32'h08; dat = 32'h66; sel = 4'hF;
        {cyc_b, stb_b} = 2'b11;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen |= ack_b;
        end
        stb_b = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen |= ack_b;
        end
        cyc_b = 1'b0; we = 1'b0;
        check("abort_no_ack", 32'(seen), 32'd0);
        rd("abort_status", 1, 32'h04, 32'h0000_0108);
        check("b_tx_head", txd_b, 32'h55);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
